single_packet_checker_64: RTL and testbench
===========================================

// Module: single_packet_checker_64
// PURPOSE
// H2C-side counterpart of the C2H single-packet producer: AXI4-Stream sink on the XDMA H2C stream in the user_clk domain.
// Consumes one DMA transfer of WORD_MAX+1 64-bit beats and checks every beat against the producer pattern.
// Checks data {36'h0_000A_0000, idx[27:0]}, tlast framing and tkeep.
// Exposes registered status (word/packet/error counts, first failing index) for loopback and link qualification.
// PARAMETERS
// DATA_WIDTH  64           stream data width; only 64 supported
// KEEP_WIDTH  DATA_WIDTH/8 tkeep width
// PKT_WIDTH   10           tlast expected when idx[PKT_WIDTH-1:0] is all ones (1024-beat packets)
// WORD_MAX    28'h000_0FFF index of final beat of a transfer (4096 beats)
// ERR_WIDTH   16           error counter width, saturating
// PORTS
// user_clk        in   1          single clock, all logic rising-edge
// user_rst        in   1          asynchronous reset, active-high
// dma_ena         in   1          level; high arms/runs a check, low returns to IDLE
// stall           in   1          sync backpressure request; forces s_axis_tready low
// s_axis_tdata    in   DATA_WIDTH stream data
// s_axis_tkeep    in   KEEP_WIDTH stream byte enables, must be all ones
// s_axis_tvalid   in   1          source valid
// s_axis_tready   out  1          sink ready
// s_axis_tlast    in   1          packet end marker
// done            out  1          final beat (idx==WORD_MAX) accepted
// error           out  1          sticky: any beat error or overrun this run
// overrun         out  1          sticky: beat accepted while in DONE
// word_count      out  28         beats accepted this run (incl. overrun beats)
// pkt_count       out  16         accepted beats with tlast=1, wraps
// err_count       out  ERR_WIDTH  beats with >=1 error, incl. overrun beats; saturates at all ones
// first_err_idx   out  28         expected idx of first erroneous beat; valid when error=1
// BEHAVIOUR
// Reset (user_rst=1, async): state=IDLE; all outputs 0; internal idx=0.
// Beat accepted = s_axis_tvalid & s_axis_tready on a rising edge.
// FSM states IDLE, RUN, DONE:
//  IDLE: tready=0. dma_ena=1 -> RUN; same edge clears idx, done, error, overrun and all counts.
//  RUN : tready = !stall (combinational from stall and state only, never from tvalid).
//        Per accepted beat:
//         data_err = tdata != {36'h0_000A_0000, idx}
//         last_err = tlast != (idx[PKT_WIDTH-1:0] == all ones)
//         keep_err = tkeep != all ones
//        Any error: err_count+1 (saturating); error<=1.
//        first_err_idx <= idx, only on the first error of the run.
//        idx <= idx+1 always; no resync to received data.
//        Accepted beat with idx==WORD_MAX -> DONE, done<=1.
//        dma_ena=0 -> IDLE; a beat accepted on that same edge is still checked and counted.
//  DONE: tready = 1 (drain).
//        Each accepted beat: overrun<=1, error<=1, err_count+1 (saturating), word_count+1.
//        first_err_idx not updated by overrun beats.
//        dma_ena=0 -> IDLE.
// Status outputs registered; update on the edge that accepts the beat (visible the following cycle).
// Status held in IDLE until next IDLE->RUN.
// Counts use plain binary arithmetic: word_count 28-bit, pkt_count 16-bit wrap; err_count saturates at all ones.
// stall asserted with tvalid=1: beat not accepted; tdata/tlast may change freely while tvalid=0.
// dma_ena drop mid-RUN: partial results held, done stays 0.
// Reset mid-operation: immediate return to IDLE with all outputs 0; no partial state retained.
// TESTING
// T1 clean: 4096 beats, tlast at idx 1023/2047/3071/4095, stall=0 -> done=1, pkt_count=4, word_count=4096, err_count=0, error=0.
// T2 data corruption: beat 100 tdata bit 0 flipped -> err_count=1, first_err_idx=100, error=1, done=1 at end, pkt_count=4.
// T3 framing: extra tlast at idx 500, missing tlast at 1023 -> err_count=2, first_err_idx=500, pkt_count=4.
// T4 handshake: random tvalid gaps, stall every 3rd cycle -> no acceptance while stall=1; final status identical to T1.
// T5 overrun: 4098 beats -> done=1, overrun=1, error=1, err_count=2, word_count=4098.
// T6 reset/abort: user_rst pulse at idx 2000 -> next cycle all outputs 0, tready=0. Rerun T1 passes. dma_ena drop at idx 300 -> word_count=300, done=0 held.

Source files
------------

// File: rtl/single_packet_checker_64.sv
// AXI4-Stream sink that checks one H2C DMA transfer of WORD_MAX+1 beats against
// the producer pattern {36'h0_000A_0000, idx} with tlast every 2**PKT_WIDTH beats.
//   state   | meaning
//   IDLE    | not ready; status held from the last run
//   RUN     | checking beats, ready unless stalled
//   DONE    | final beat seen; drains and flags any further beat as overrun
module single_packet_checker_64 #(
  parameter int          DATA_WIDTH = 64,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int          PKT_WIDTH  = 10,
  parameter logic [27:0] WORD_MAX   = 28'h000_0FFF,
  parameter int          ERR_WIDTH  = 16
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic                  dma_ena,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  done,
  output logic                  error,
  output logic                  overrun,
  output logic [27:0]           word_count,
  output logic [15:0]           pkt_count,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [27:0]           first_err_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [27:0]            idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   overrun_q, overrun_d;
  logic [27:0]            word_cnt_q, word_cnt_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;
  logic [ERR_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic [27:0]            first_err_q, first_err_d;

  logic                   beat_acc;
  logic [DATA_WIDTH-1:0]  exp_data;
  logic                   beat_err;
  logic [ERR_WIDTH-1:0]   err_cnt_inc;

  // Ready depends only on state and stall so a source may wait on it safely.
  assign s_axis_tready = (state_q == ST_RUN) ? !stall : (state_q == ST_DONE);
  assign beat_acc      = s_axis_tvalid & s_axis_tready;

  assign exp_data    = {36'h0_000A_0000, idx_q};
  assign beat_err    = (s_axis_tdata != exp_data)
                     | (s_axis_tlast != (&idx_q[PKT_WIDTH-1:0]))
                     | (s_axis_tkeep != {KEEP_WIDTH{1'b1}});
  assign err_cnt_inc = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = done_q;
    error_d     = error_q;
    overrun_d   = overrun_q;
    word_cnt_d  = word_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    case (state_q)
      ST_IDLE: begin
        if (dma_ena) begin
          state_d     = ST_RUN;
          idx_d       = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          overrun_d   = 1'b0;
          word_cnt_d  = '0;
          pkt_cnt_d   = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
        end
      end

      ST_RUN: begin
        if (beat_acc) begin
          idx_d      = idx_q + 28'd1;
          word_cnt_d = word_cnt_q + 28'd1;
          if (s_axis_tlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
          if (beat_err) begin
            err_cnt_d = err_cnt_inc;
            error_d   = 1'b1;
            if (!error_q) first_err_d = idx_q;
          end
          if (idx_q == WORD_MAX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        // An abort still keeps the bookkeeping of a beat taken on the same edge.
        if (!dma_ena) state_d = ST_IDLE;
      end

      ST_DONE: begin
        if (beat_acc) begin
          overrun_d  = 1'b1;
          error_d    = 1'b1;
          err_cnt_d  = err_cnt_inc;
          word_cnt_d = word_cnt_q + 28'd1;
          if (s_axis_tlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (!dma_ena) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      overrun_q   <= 1'b0;
      word_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      error_q     <= error_d;
      overrun_q   <= overrun_d;
      word_cnt_q  <= word_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign done          = done_q;
  assign error         = error_q;
  assign overrun       = overrun_q;
  assign word_count    = word_cnt_q;
  assign pkt_count     = pkt_cnt_q;
  assign err_count     = err_cnt_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_single_packet_checker_64.sv
// Randomized bench for single_packet_checker_64: drives producer-pattern transfers
// with injected faults and compares status against a beat-level reference model.
module tb_single_packet_checker_64;

  localparam int WORDS = 4096;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic        dma_ena;
  logic        stall;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        done;
  logic        error;
  logic        overrun;
  logic [27:0] word_count;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic [27:0] first_err_idx;

  single_packet_checker_64 dut (
    .user_clk      (user_clk),
    .user_rst      (user_rst),
    .dma_ena       (dma_ena),
    .stall         (stall),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .done          (done),
    .error         (error),
    .overrun       (overrun),
    .word_count    (word_count),
    .pkt_count     (pkt_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 checking, 2 transfer complete.
  int m_phase;
  int m_words, m_pkts, m_errs, m_first;
  bit m_done, m_error, m_overrun;

  task automatic model_clear();
    m_words = 0; m_pkts = 0; m_errs = 0; m_first = 0;
    m_done = 0; m_error = 0; m_overrun = 0;
  endtask

  task automatic model_beat(input int k, input logic [63:0] d, input logic l, input logic [7:0] kp);
    logic [63:0] want;
    bit          bad;
    want = {36'h0_000A_0000, 28'(k)};
    m_words++;
    if (l) m_pkts++;
    if (m_phase == 1) begin
      bad = (d != want) || (l != ((k % 1024) == 1023)) || (kp != 8'hFF);
      if (bad) begin
        if (!m_error) m_first = k;
        m_error = 1;
        m_errs++;
      end
      if (k == WORDS - 1) begin
        m_done  = 1;
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_overrun = 1;
      m_error   = 1;
      m_errs++;
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".done"},    done,       m_done);
    check_eq({tag, ".error"},   error,      m_error);
    check_eq({tag, ".overrun"}, overrun,    m_overrun);
    check_eq({tag, ".words"},   word_count, m_words);
    check_eq({tag, ".pkts"},    pkt_count,  m_pkts % 65536);
    check_eq({tag, ".errs"},    err_count,  (m_errs > 65535) ? 65535 : m_errs);
    if (m_error) check_eq({tag, ".first"}, first_err_idx, m_first);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".tready"},  tready,        0);
    check_eq({tag, ".done"},    done,          0);
    check_eq({tag, ".error"},   error,         0);
    check_eq({tag, ".overrun"}, overrun,       0);
    check_eq({tag, ".words"},   word_count,    0);
    check_eq({tag, ".pkts"},    pkt_count,     0);
    check_eq({tag, ".errs"},    err_count,     0);
    check_eq({tag, ".first"},   first_err_idx, 0);
  endtask

  // Sends beats until n are accepted, or stops early for an abort/reset at beat index.
  task automatic run_stream(input string tag, input int n, input int flip_at, input int extra_at,
                            input int miss_at, input int keep_at, input bit gaps,
                            input int stall_per, input int abort_at, input int rst_at);
    int          k;
    int          cyc;
    bit          acc;
    bit          exp_rdy;
    logic [63:0] d;
    logic        l;
    logic [7:0]  kp;
    k = 0;
    cyc = 0;
    @(negedge user_clk);
    stall = 0; tvalid = 0; dma_ena = 1;
    #1 check_eq({tag, ".idle_tready"}, tready, 0);
    @(posedge user_clk);
    model_clear();
    m_phase = 1;
    while (k < n) begin
      if (cyc > n * 6 + 100) begin
        check_eq({tag, ".timeout"}, k, n);
        break;
      end
      @(negedge user_clk);
      cyc++;
      if (k == rst_at) begin
        user_rst = 1; tvalid = 0; dma_ena = 0; stall = 0;
        #1 check_zero({tag, ".rst"});
        @(negedge user_clk);
        user_rst = 0;
        model_clear();
        m_phase = 0;
        return;
      end
      if (k == abort_at) begin
        dma_ena = 0; tvalid = 0; stall = 0;
        @(posedge user_clk);
        m_phase = 0;
        return;
      end
      stall  = (stall_per > 0) && ((cyc % stall_per) == 0);
      tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d  = {36'h0_000A_0000, 28'(k)};
      if (k == flip_at) d[0] = ~d[0];
      l  = ((k % 1024) == 1023);
      if (k == extra_at) l = 1'b1;
      if (k == miss_at)  l = 1'b0;
      kp = (k == keep_at) ? 8'h7F : 8'hFF;
      if (tvalid) begin
        tdata = d; tlast = l; tkeep = kp;
      end else begin
        tdata = {$urandom, $urandom}; tlast = 1'($urandom); tkeep = 8'($urandom);
      end
      #1;
      exp_rdy = (m_phase == 1) ? !stall : (m_phase == 2);
      check_eq({tag, ".tready"}, tready, exp_rdy);
      acc = tvalid && exp_rdy;
      @(posedge user_clk);
      if (acc) begin
        model_beat(k, d, l, kp);
        k++;
      end
    end
    @(negedge user_clk);
    tvalid = 0; stall = 0;
  endtask

  task automatic finish_run(input string tag);
    repeat (2) @(negedge user_clk);
    check_status(tag);
    dma_ena = 0;
    @(negedge user_clk);
    m_phase = 0;
    check_eq({tag, ".held_tready"}, tready, 0);
    check_status({tag, ".held"});
  endtask

  initial begin
    user_rst = 1; dma_ena = 0; stall = 0; tvalid = 0;
    tdata = '0; tkeep = '0; tlast = 0;
    model_clear();
    m_phase = 0;
    repeat (3) @(negedge user_clk);
    check_zero("reset");
    user_rst = 0;
    repeat (2) @(negedge user_clk);

    run_stream("T1", WORDS, -1, -1, -1, -1, 0, 0, -1, -1);
    finish_run("T1");

    run_stream("T2", WORDS, 100, -1, -1, -1, 0, 0, -1, -1);
    finish_run("T2");

    run_stream("T3", WORDS, -1, 500, 1023, -1, 0, 0, -1, -1);
    finish_run("T3");

    run_stream("T4", WORDS, -1, -1, -1, -1, 1, 3, -1, -1);
    finish_run("T4");

    run_stream("T5", WORDS + 2, -1, -1, -1, -1, 0, 0, -1, -1);
    finish_run("T5");

    run_stream("T6rst", WORDS, -1, -1, -1, -1, 1, 0, -1, 2000);
    repeat (2) @(negedge user_clk);
    check_zero("T6rst.after");
    run_stream("T6rerun", WORDS, -1, -1, -1, -1, 0, 0, -1, -1);
    finish_run("T6rerun");

    run_stream("T6abort", WORDS, -1, -1, -1, -1, 0, 0, 300, -1);
    repeat (3) @(negedge user_clk);
    check_eq("T6abort.words", word_count, 300);
    check_eq("T6abort.done", done, 0);
    check_eq("T6abort.tready", tready, 0);
    check_status("T6abort");

    for (int r = 0; r < 2; r++) begin
      run_stream("RND", WORDS, int'($urandom_range(0, WORDS - 1)), int'($urandom_range(0, WORDS - 1)),
                 -1, int'($urandom_range(0, WORDS - 1)), 1, int'($urandom_range(2, 5)), -1, -1);
      finish_run("RND");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
